// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I/RV64I execute stage. Decodes ALUOp/fun7/fun3 into a
// 4-bit control code, runs an XLEN-wide ALU and holds the result in an output
// register with valid/ready handshakes on both the issue and result sides.
//
// Build option ALU_FAST_SHIFT_EN: single-cycle barrel shifter, no SHIFT state.
// Default build: iterative shifter, one bit per cycle, counter loaded with shamt.
//
// state | meaning
// IDLE  | can accept an op (subject to output back-pressure)
// SHIFT | iterative shift in flight, in_ready held low
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic            fun7,
    input  logic [2:0]      fun3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic [3:0]      ctrl_out
);
    localparam int SHAMT_W = $clog2(XLEN);

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLL  = 4'b0100;
    localparam logic [3:0] C_SRL  = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SRA  = 4'b0111;
    localparam logic [3:0] C_SLT  = 4'b1000;
    localparam logic [3:0] C_SLTU = 4'b1001;

    logic [3:0]         dec_ctrl;
    logic               dec_illegal;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_res;
    logic               accept;

    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;
    logic [3:0]         ctrl_q, ctrl_d;

    assign shamt = op_b[SHAMT_W-1:0];

    // Decode alu_op/fun7/fun3 into a control code; unsupported encodings map to code 0000
    always_comb begin
        dec_ctrl    = C_ADD;
        dec_illegal = 1'b0;
        case (alu_op)
            2'b00: dec_ctrl = C_ADD;
            2'b01: dec_ctrl = C_SUB;
            default: begin
                case (fun3)
                    3'b000:  dec_ctrl = (alu_op == 2'b10 && fun7) ? C_SUB : C_ADD;
                    3'b001:  dec_ctrl = C_SLL;
                    3'b010:  dec_ctrl = C_SLT;
                    3'b011:  dec_ctrl = C_SLTU;
                    3'b100:  dec_ctrl = C_XOR;
                    3'b101:  dec_ctrl = fun7 ? C_SRA : C_SRL;
                    3'b110:  dec_ctrl = C_OR;
                    default: dec_ctrl = C_AND;
                endcase
                if (fun7 && ((alu_op == 2'b10 && fun3 != 3'b000 && fun3 != 3'b101) ||
                             (alu_op == 2'b11 && fun3 == 3'b001))) begin
                    dec_illegal = 1'b1;
                    dec_ctrl    = C_AND;
                end
            end
        endcase
    end

    // Single-cycle datapath; without the barrel shifter it only covers shamt=0 shifts
    always_comb begin
        alu_res = '0;
        case (dec_ctrl)
            C_AND:  alu_res = op_a & op_b;
            C_OR:   alu_res = op_a | op_b;
            C_ADD:  alu_res = op_a + op_b;
            C_XOR:  alu_res = op_a ^ op_b;
            C_SUB:  alu_res = op_a + ~op_b + XLEN'(1);
            C_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
            C_SLTU: alu_res = XLEN'(op_a < op_b);
`ifdef ALU_FAST_SHIFT_EN
            C_SLL:  alu_res = op_a << shamt;
            C_SRL:  alu_res = op_a >> shamt;
            C_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
`else
            C_SLL, C_SRL, C_SRA: alu_res = op_a;
`endif
            default: alu_res = '0;
        endcase
        if (dec_illegal) begin
            alu_res = '0;
        end
    end

`ifdef ALU_FAST_SHIFT_EN
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Every accepted op lands in the output register on its accept edge
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        illegal_d   = illegal_q;
        ctrl_d      = ctrl_q;
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            illegal_d   = dec_illegal;
            ctrl_d      = dec_ctrl;
        end
        zero_d = (result_d == '0);
    end
`else
    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]    sh_q, sh_d, sh_step;
    logic [3:0]         sh_ctrl_q, sh_ctrl_d;
    logic               is_shift;

    assign is_shift = (dec_ctrl == C_SLL) || (dec_ctrl == C_SRL) || (dec_ctrl == C_SRA);
    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // One-bit step of the operand being shifted; SRA replicates the sign bit
    always_comb begin
        case (sh_ctrl_q)
            C_SLL:   sh_step = {sh_q[XLEN-2:0], 1'b0};
            C_SRL:   sh_step = {1'b0, sh_q[XLEN-1:1]};
            default: sh_step = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
        endcase
    end

    // Next state, shift counter and output register update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        sh_ctrl_d   = sh_ctrl_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        illegal_d   = illegal_q;
        ctrl_d      = ctrl_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_shift && shamt != '0) begin
                        state_d   = S_SHIFT;
                        cnt_d     = shamt;
                        sh_d      = op_a;
                        sh_ctrl_d = dec_ctrl;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        illegal_d   = dec_illegal;
                        ctrl_d      = dec_ctrl;
                    end
                end
            end
            S_SHIFT: begin
                sh_d  = sh_step;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = sh_step;
                    illegal_d   = 1'b0;
                    ctrl_d      = sh_ctrl_q;
                end
            end
        endcase
        zero_d = (result_d == '0);
    end

    // Shifter state; reset drops any in-flight shift
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            sh_ctrl_q <= C_AND;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            sh_ctrl_q <= sh_ctrl_d;
        end
    end
`endif

    // Output register, held while the consumer back-pressures
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            illegal_q   <= 1'b0;
            ctrl_q      <= C_AND;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign ctrl_out  = ctrl_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vector table, hand sequences for back-to-back,
// stall and mid-shift reset, then random ops against a behavioural model.
module tb_alu_exec_unit;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic        fun7;
    logic [2:0]  fun3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic [3:0]  ctrl_out;

    int n_vec = 0;
    int n_err = 0;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .fun7      (fun7),
        .fun3      (fun3),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .ctrl_out  (ctrl_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  aop;
        logic        f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        logic [3:0]  ctl;
        int          lat;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b, want %0b", name, act, exp);
        end
    endtask

    // Behavioural reference: decode and compute straight from the ISA rules
    function automatic void ref_model(input logic [1:0] aop, input logic f7, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic ill,
                                      output logic [3:0] ctl, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        r   = '0;
        ill = 1'b0;
        ctl = 4'b0000;
        lat = 1;
        if (aop == 2'b00) begin
            ctl = 4'b0010; r = a + b;
        end else if (aop == 2'b01) begin
            ctl = 4'b0110; r = a - b;
        end else if (f7 && ((aop == 2'b10 && f3 != 3'd0 && f3 != 3'd5) ||
                            (aop == 2'b11 && f3 == 3'd1))) begin
            ill = 1'b1;
        end else begin
            case (f3)
                3'd0: begin
                    if (aop == 2'b10 && f7) begin ctl = 4'b0110; r = a - b; end
                    else begin ctl = 4'b0010; r = a + b; end
                end
                3'd1: begin ctl = 4'b0100; r = a << sh; lat = sh + 1; end
                3'd2: begin ctl = 4'b1000; r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                3'd3: begin ctl = 4'b1001; r = (a < b) ? 32'd1 : 32'd0; end
                3'd4: begin ctl = 4'b0011; r = a ^ b; end
                3'd5: begin
                    if (f7) begin ctl = 4'b0111; r = $unsigned($signed(a) >>> sh); end
                    else begin ctl = 4'b0101; r = a >> sh; end
                    lat = sh + 1;
                end
                3'd6: begin ctl = 4'b0001; r = a | b; end
                default: begin ctl = 4'b0000; r = a & b; end
            endcase
        end
    endfunction

    // Issue one op, scramble inputs while busy, then check latency, busy cycles and outputs.
    // Called at a negedge; returns at a negedge with out_ready=1.
    task automatic apply(input string name, input logic [1:0] aop, input logic f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic eil, input logic [3:0] ec, input int elat,
                         input int hold, output int waited);
        int lat;
        int busy;
        int el;
        el = elat;
`ifdef ALU_FAST_SHIFT_EN
        el = 1;
`endif
        alu_op = aop; fun7 = f7; fun3 = f3; op_a = a; op_b = b;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check1($sformatf("%s_in_ready", name), in_ready, 1'b1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        alu_op = 2'($urandom); fun7 = 1'($urandom); fun3 = 3'($urandom);
        op_a = $urandom; op_b = $urandom;
        lat = 0;
        busy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!in_ready) busy++;
        end while (!out_valid && lat < 200);
        in_valid  = 1'b0;
        out_ready = (hold == 0);
        check($sformatf("%s_latency", name), lat, el);
        check($sformatf("%s_busy", name), busy, el - 1);
        check($sformatf("%s_result", name), result, er);
        check1($sformatf("%s_zero", name), zero, er == 32'd0);
        check1($sformatf("%s_illegal", name), illegal, eil);
        check($sformatf("%s_ctrl", name), {28'd0, ctrl_out}, {28'd0, ec});
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check1($sformatf("%s_hold%0d_valid", name, k), out_valid, 1'b1);
            check($sformatf("%s_hold%0d_result", name, k), result, er);
            check1($sformatf("%s_hold%0d_in_ready", name, k), in_ready, 1'b0);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        int          waited;
        int          spurious;
        logic [31:0] rr;
        logic        ri;
        logic [3:0]  rc;
        int          rl;
        logic [1:0]  raop;
        logic        rf7;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;

        //         aop    f7    f3      a             b             result        ill   ctl      lat
        vecs[0]  = '{2'b00, 1'b1, 3'b111, 32'd5,        32'd7,        32'd12,       1'b0, 4'b0010, 1};
        vecs[1]  = '{2'b01, 1'b1, 3'b101, 32'd9,        32'd9,        32'd0,        1'b0, 4'b0110, 1};
        vecs[2]  = '{2'b10, 1'b0, 3'b000, 32'd5,        32'd7,        32'd12,       1'b0, 4'b0010, 1};
        vecs[3]  = '{2'b10, 1'b1, 3'b000, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 4'b0110, 1};
        vecs[4]  = '{2'b10, 1'b1, 3'b111, 32'hF0,       32'hFF,       32'd0,        1'b1, 4'b0000, 1};
        vecs[5]  = '{2'b10, 1'b0, 3'b111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 4'b0000, 1};
        vecs[6]  = '{2'b10, 1'b0, 3'b110, 32'h000000F0, 32'h00000F00, 32'h00000FF0, 1'b0, 4'b0001, 1};
        vecs[7]  = '{2'b10, 1'b0, 3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 4'b0011, 1};
        vecs[8]  = '{2'b10, 1'b0, 3'b010, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 4'b1000, 1};
        vecs[9]  = '{2'b10, 1'b0, 3'b011, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 4'b1001, 1};
        vecs[10] = '{2'b11, 1'b0, 3'b001, 32'd1,        32'd31,       32'h80000000, 1'b0, 4'b0100, 32};
        vecs[11] = '{2'b10, 1'b0, 3'b101, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 4'b0101, 5};
        vecs[12] = '{2'b10, 1'b1, 3'b101, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 4'b0111, 5};
        vecs[13] = '{2'b11, 1'b1, 3'b101, 32'h70000000, 32'h21,       32'h38000000, 1'b0, 4'b0111, 2};
        vecs[14] = '{2'b11, 1'b1, 3'b001, 32'h12345678, 32'd3,        32'd0,        1'b1, 4'b0000, 1};
        vecs[15] = '{2'b10, 1'b0, 3'b001, 32'h12345678, 32'h20,       32'h12345678, 1'b0, 4'b0100, 1};
        vecs[16] = '{2'b11, 1'b1, 3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 4'b0010, 1};
        vecs[17] = '{2'b10, 1'b1, 3'b010, 32'd3,        32'd5,        32'd0,        1'b1, 4'b0000, 1};
        vecs[18] = '{2'b11, 1'b1, 3'b010, 32'd3,        32'd5,        32'd1,        1'b0, 4'b1000, 1};
        vecs[19] = '{2'b10, 1'b1, 3'b001, 32'd3,        32'd5,        32'd0,        1'b1, 4'b0000, 1};
        vecs[20] = '{2'b01, 1'b0, 3'b000, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 4'b0110, 1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; fun7 = 1'b0; fun3 = 3'b000; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_zero", zero, 1'b1);
        check("rst_result", result, 32'd0);
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_illegal", illegal, 1'b0);
        check("rst_ctrl", {28'd0, ctrl_out}, 32'd0);

        // Back-to-back ADD then SUB, one result per cycle
        alu_op = 2'b10; fun7 = 1'b0; fun3 = 3'b000; op_a = 32'd5; op_b = 32'd7;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 fun7 = 1'b1;
        @(negedge clk);
        check1("b2b_first_valid", out_valid, 1'b1);
        check("b2b_first_result", result, 32'd12);
        check1("b2b_first_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check1("b2b_second_valid", out_valid, 1'b1);
        check("b2b_second_result", result, 32'hFFFFFFFE);
        check("b2b_second_ctrl", {28'd0, ctrl_out}, 32'h6);
        @(negedge clk);
        check1("b2b_drained", out_valid, 1'b0);

        for (int i = 0; i < 21; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].aop, vecs[i].f7, vecs[i].f3, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].ill, vecs[i].ctl, vecs[i].lat, 0, waited);
        end

        // Stall 3 cycles after an ADD, then release with a new op issued in the same cycle
        apply("stall_add", 2'b00, 1'b0, 3'b000, 32'd100, 32'd23, 32'd123, 1'b0, 4'b0010, 1, 3, waited);
        apply("stall_next", 2'b10, 1'b0, 3'b100, 32'hAAAA5555, 32'hFFFFFFFF, 32'h5555AAAA,
              1'b0, 4'b0011, 1, 0, waited);
        check("stall_release_wait", waited, 0);

        // Reset in the middle of an SRL by 20
        alu_op = 2'b10; fun7 = 1'b0; fun3 = 3'b101; op_a = 32'hFFFFFFFF; op_b = 32'd20;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check1("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check1("midrst_out_valid", out_valid, 1'b0);
        check1("midrst_in_ready_after", in_ready, 1'b1);
        check("midrst_result", result, 32'd0);
        check1("midrst_zero", zero, 1'b1);
        check("midrst_ctrl", {28'd0, ctrl_out}, 32'd0);
        spurious = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("midrst_no_late_result", spurious, 0);
        apply("post_rst", vecs[2].aop, vecs[2].f7, vecs[2].f3, vecs[2].a, vecs[2].b,
              vecs[2].res, vecs[2].ill, vecs[2].ctl, vecs[2].lat, 0, waited);

        for (int i = 0; i < 80; i++) begin
            raop = 2'($urandom);
            rf7  = 1'($urandom);
            rf3  = 3'($urandom);
            ra   = $urandom;
            rb   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 40) : $urandom;
            ref_model(raop, rf7, rf3, ra, rb, rr, ri, rc, rl);
            apply($sformatf("rnd%0d", i), raop, rf7, rf3, ra, rb, rr, ri, rc, rl,
                  $urandom_range(0, 2), waited);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
